// File: rtl/hdma_controller.sv
// hdma_controller: GBC HDMA/GDMA engine. Owns HDMA1..HDMA5 and copies
// 16-byte blocks from ROM/ERAM/WRAM into VRAM as a second bus master.
// Each byte takes one read cycle followed by one write cycle.
module hdma_controller (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic [15:0] I_IOREG_ADDR,
  inout  wire  [7:0]  IO_IOREG_DATA,
  input  logic        I_IOREG_WE_L,
  input  logic        I_IOREG_RE_L,
  input  logic        I_HBLANK,
  input  logic        I_IN_DMG_MODE,
  output logic        O_BUS_REQ,
  output logic [15:0] O_MEM_ADDR,
  inout  wire  [7:0]  IO_MEM_DATA,
  output logic        O_MEM_WE_L,
  output logic        O_MEM_RE_L
);

  localparam logic [15:0] ADDR_HDMA1 = 16'hFF51;
  localparam logic [15:0] ADDR_HDMA2 = 16'hFF52;
  localparam logic [15:0] ADDR_HDMA3 = 16'hFF53;
  localparam logic [15:0] ADDR_HDMA4 = 16'hFF54;
  localparam logic [15:0] ADDR_HDMA5 = 16'hFF55;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HWAIT = 2'd1;
  localparam logic [1:0] S_RD    = 2'd2;
  localparam logic [1:0] S_WR    = 2'd3;

  logic [1:0]  state;
  logic [15:0] src;
  logic [12:0] dst;
  logic [6:0]  len;
  logic [3:0]  cnt;
  logic [7:0]  hold;
  logic        hdma_mode;
  logic        served;

  logic       wr_en;
  logic [7:0] wdata;
  logic       reg_hit;
  logic [7:0] rdata;

  assign wr_en = ~I_IOREG_WE_L & ~I_IN_DMG_MODE;
  assign wdata = IO_IOREG_DATA;

  // Register file, FSM and byte mover. DMG mode pins the FSM in IDLE.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state     <= S_IDLE;
      src       <= 16'h0000;
      dst       <= 13'h0000;
      len       <= 7'h7F;
      cnt       <= 4'h0;
      hold      <= 8'h00;
      hdma_mode <= 1'b0;
      served    <= 1'b0;
    end else if (I_IN_DMG_MODE) begin
      state <= S_IDLE;
    end else begin
      // served is re-armed only outside HBlank: one block per HBlank
      if (!I_HBLANK) served <= 1'b0;

      // source/destination are only writable while nothing is in flight
      if (wr_en && state == S_IDLE) begin
        case (I_IOREG_ADDR)
          ADDR_HDMA1: src[15:8] <= wdata;
          ADDR_HDMA2: src[7:0]  <= {wdata[7:4], 4'h0};
          ADDR_HDMA3: dst[12:8] <= wdata[4:0];
          ADDR_HDMA4: dst[7:0]  <= {wdata[7:4], 4'h0};
          default: ;
        endcase
      end

      case (state)
        S_IDLE: begin
          if (wr_en && I_IOREG_ADDR == ADDR_HDMA5) begin
            len       <= wdata[6:0];
            hdma_mode <= wdata[7];
            cnt       <= 4'h0;
            state     <= wdata[7] ? S_HWAIT : S_RD;
          end
        end
        S_HWAIT: begin
          if (wr_en && I_IOREG_ADDR == ADDR_HDMA5) begin
            // bit7=1 reloads the length, bit7=0 cancels keeping LEN
            if (wdata[7]) len <= wdata[6:0];
            else          state <= S_IDLE;
          end else if (I_HBLANK && !served) begin
            served <= 1'b1;
            state  <= S_RD;
          end
        end
        S_RD: begin
          hold  <= IO_MEM_DATA;
          state <= S_WR;
        end
        default: begin  // S_WR
          src <= src + 16'd1;
          dst <= dst + 13'd1;
          cnt <= cnt + 4'd1;
          if (cnt == 4'hF) begin
            if (len == 7'h00) begin
              // completion leaves HDMA5 reading 0xFF
              len   <= 7'h7F;
              state <= S_IDLE;
            end else begin
              len   <= len - 7'd1;
              state <= hdma_mode ? S_HWAIT : S_RD;
            end
          end else begin
            state <= S_RD;
          end
        end
      endcase
    end
  end

  // Bus master outputs decode straight from the state so reset clears them at once
  always_comb begin
    O_BUS_REQ  = (state == S_RD) || (state == S_WR);
    O_MEM_RE_L = ~(state == S_RD);
    O_MEM_WE_L = ~(state == S_WR);
    O_MEM_ADDR = 16'h0000;
    if (state == S_RD)      O_MEM_ADDR = src;
    else if (state == S_WR) O_MEM_ADDR = {3'b100, dst};
  end

  // Register read mux: only HDMA5 carries information
  always_comb begin
    reg_hit = (I_IOREG_ADDR >= ADDR_HDMA1) && (I_IOREG_ADDR <= ADDR_HDMA5);
    rdata   = 8'hFF;
    if (!I_IN_DMG_MODE && I_IOREG_ADDR == ADDR_HDMA5)
      rdata = {state == S_IDLE, len};
  end

  assign IO_IOREG_DATA = (!I_IOREG_RE_L && reg_hit) ? rdata : 8'hzz;
  assign IO_MEM_DATA   = (state == S_WR) ? hold : 8'hzz;

endmodule

// File: tb/tb_hdma_controller.sv
// tb_hdma_controller: directed stimulus with scoreboarded VRAM writes and
// bus-ownership burst lengths, plus direct register/strobe checks.
module tb_hdma_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] io_addr = 16'h0000;
  logic        io_we_l = 1'b1;
  logic        io_re_l = 1'b1;
  logic        io_drv  = 1'b0;
  logic [7:0]  io_wdata = 8'h00;
  logic        hblank = 1'b0;
  logic        dmg = 1'b0;
  wire  [7:0]  ioreg_data;
  wire  [7:0]  mem_data;
  logic        bus_req;
  logic [15:0] mem_addr;
  logic        mem_we_l;
  logic        mem_re_l;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t wq[$];
  int  bq[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  sb_en = 1'b1;

  // source memory contents: WRAM page C0 holds its own offset
  function automatic logic [7:0] memval(input logic [15:0] a);
    return (a[15:8] == 8'hC0) ? a[7:0] : (a[7:0] ^ 8'hA5);
  endfunction

  assign ioreg_data = io_drv ? io_wdata : 8'hzz;
  assign mem_data   = !mem_re_l ? memval(mem_addr) : 8'hzz;

  hdma_controller dut (
    .I_CLK(clk), .I_RESET(rst),
    .I_IOREG_ADDR(io_addr), .IO_IOREG_DATA(ioreg_data),
    .I_IOREG_WE_L(io_we_l), .I_IOREG_RE_L(io_re_l),
    .I_HBLANK(hblank), .I_IN_DMG_MODE(dmg),
    .O_BUS_REQ(bus_req), .O_MEM_ADDR(mem_addr), .IO_MEM_DATA(mem_data),
    .O_MEM_WE_L(mem_we_l), .O_MEM_RE_L(mem_re_l)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr_reg(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    io_addr = a; io_wdata = d; io_drv = 1'b1; io_we_l = 1'b0;
    @(negedge clk);
    io_we_l = 1'b1; io_drv = 1'b0;
  endtask

  task automatic rd_reg(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    io_addr = a; io_re_l = 1'b0;
    #1 d = ioreg_data;
    io_re_l = 1'b1;
  endtask

  task automatic wait_bus_low(input int bound, input string name);
    int n = 0;
    while (bus_req && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (bus_req) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: bus_req still high after %0d cycles, required low", name, bound);
    end
  endtask

  // one HBlank of 100 cycles; returns number of cycles the bus was owned
  task automatic hblank_pulse(output int busy);
    busy = 0;
    @(negedge clk);
    hblank = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (bus_req) busy++;
    end
    hblank = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus_req) busy++;
    end
  endtask

  // write scoreboard: every VRAM write cycle must match the next expectation
  wr_t mon_e;
  initial forever begin
    @(negedge clk);
    if (!rst && sb_en && !mem_we_l) begin
      if (wq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_write: got addr %h data %h, required no write", mem_addr, mem_data);
      end else begin
        mon_e = wq.pop_front();
        check("vram_write", {8'h00, mem_addr, mem_data}, {8'h00, mon_e.addr, mon_e.data});
      end
    end
  end

  // burst scoreboard: length of each contiguous bus_req run
  int run = 0;
  initial forever begin
    @(negedge clk);
    if (rst) run = 0;
    else if (bus_req) run++;
    else if (run > 0) begin
      if (bq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_burst: got %0d cycles, required none", run);
      end else begin
        check("bus_req_burst", run, bq.pop_front());
      end
      run = 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rd;
    logic [12:0] d13;
    int          busy;

    // reset state
    #1;
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_strobes", {mem_we_l, mem_re_l}, 2'b11);
    rd_reg(16'hFF55, rd);
    check("rst_hdma5", rd, 8'hFF);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // GDMA: 2 blocks from C000 to 8000
    wr_reg(16'hFF51, 8'hC0);
    wr_reg(16'hFF52, 8'h00);
    wr_reg(16'hFF53, 8'h00);
    wr_reg(16'hFF54, 8'h00);
    for (int i = 0; i < 32; i++) wq.push_back('{16'h8000 + 16'(i), 8'(i)});
    bq.push_back(64);
    wr_reg(16'hFF55, 8'h01);
    #1 check("gdma_start_bus_req", bus_req, 1'b1);
    wait_bus_low(100, "gdma_done");
    rd_reg(16'hFF55, rd);
    check("gdma_hdma5_done", rd, 8'hFF);
    rd_reg(16'hFF51, rd);
    check("hdma1_read", rd, 8'hFF);

    // HDMA: 3 blocks continuing from C020 -> 8020
    for (int i = 0; i < 48; i++)
      wq.push_back('{16'h8020 + 16'(i), memval(16'hC020 + 16'(i))});
    repeat (3) bq.push_back(32);
    wr_reg(16'hFF55, 8'h82);
    rd_reg(16'hFF55, rd);
    check("hdma_len0", rd, 8'h02);
    repeat (10) @(negedge clk);
    check("hdma_wait_no_bus", bus_req, 1'b0);
    hblank_pulse(busy);
    check("hdma_burst1", busy, 32);
    rd_reg(16'hFF55, rd);
    check("hdma_len1", rd, 8'h01);
    wr_reg(16'hFF51, 8'h40);  // must be ignored while active
    hblank_pulse(busy);
    check("hdma_burst2", busy, 32);
    rd_reg(16'hFF55, rd);
    check("hdma_len2", rd, 8'h00);
    hblank_pulse(busy);
    check("hdma_burst3", busy, 32);
    rd_reg(16'hFF55, rd);
    check("hdma_done", rd, 8'hFF);

    // cancel after one block: C050 -> 8050
    for (int i = 0; i < 16; i++)
      wq.push_back('{16'h8050 + 16'(i), memval(16'hC050 + 16'(i))});
    bq.push_back(32);
    wr_reg(16'hFF55, 8'h83);
    hblank_pulse(busy);
    check("cancel_burst", busy, 32);
    rd_reg(16'hFF55, rd);
    check("cancel_active_len", rd, 8'h02);
    wr_reg(16'hFF55, 8'h00);
    rd_reg(16'hFF55, rd);
    check("cancel_read", rd, 8'h82);
    hblank_pulse(busy);
    check("cancel_quiet1", busy, 0);
    hblank_pulse(busy);
    check("cancel_quiet2", busy, 0);

    // DMG mode: inert, reads 0xFF
    dmg = 1'b1;
    wr_reg(16'hFF55, 8'h00);
    repeat (10) @(negedge clk);
    check("dmg_no_bus", bus_req, 1'b0);
    rd_reg(16'hFF55, rd);
    check("dmg_read", rd, 8'hFF);
    dmg = 1'b0;
    rd_reg(16'hFF55, rd);
    check("dmg_exit_read", rd, 8'h82);

    // source low nibble masking and 13-bit destination wrap
    wr_reg(16'hFF51, 8'h10);
    wr_reg(16'hFF52, 8'h3F);
    wr_reg(16'hFF53, 8'h1F);
    wr_reg(16'hFF54, 8'hF0);
    for (int i = 0; i < 32; i++) begin
      d13 = 13'h1FF0 + 13'(i);
      wq.push_back('{{3'b100, d13}, memval(16'h1030 + 16'(i))});
    end
    bq.push_back(64);
    wr_reg(16'hFF55, 8'h01);
    #1 check("src_low_masked", mem_addr, 16'h1030);
    check("first_rd_strobe", mem_re_l, 1'b0);
    wait_bus_low(100, "wrap_done");
    rd_reg(16'hFF55, rd);
    check("wrap_hdma5_done", rd, 8'hFF);

    // asynchronous reset mid-GDMA
    sb_en = 1'b0;
    wr_reg(16'hFF55, 8'h00);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_bus_req", bus_req, 1'b0);
    check("midrst_strobes", {mem_we_l, mem_re_l}, 2'b11);
    check("midrst_addr", mem_addr, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sb_en = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_abandoned", bus_req, 1'b0);
    rd_reg(16'hFF55, rd);
    check("midrst_hdma5", rd, 8'hFF);

    repeat (5) @(negedge clk);
    check("writes_outstanding", wq.size(), 0);
    check("bursts_outstanding", bq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
